ttio_icb_bridge: RTL
====================

TTIO_ICB_BRIDGE -- requirements
Module: ttio_icb_bridge

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 2, command FIFO entries (legal values 1..4).
REQ-002 SHALL have parameter MAX_OUTS, default 2, maximum issued-but-unanswered commands (legal values 1..7).
REQ-003 SHALL have parameter RSP_TIMEOUT, default 255, response-timeout cycle count (legal values 1..65535, used only under REQ-024).
REQ-004 SHALL provide these ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- ttio_icb_cmd_valid/ready  in/out  1/1  upstream command handshake from TTIO.
- ttio_icb_cmd_addr, ttio_icb_cmd_wdata  in  E203_ADDR_SIZE, E203_XLEN  command address and write data.
- ttio_icb_cmd_read, ttio_icb_cmd_usign  in  1 each  command read flag and unsigned flag.
- ttio_icb_cmd_wmask, ttio_icb_cmd_size  in  E203_XLEN/8, 2  command byte mask and size.
- ttio_icb_cmd_itag  in  E203_ITAG_WIDTH  command instruction tag.
- ttio_icb_rsp_valid/ready  out/in  1/1  upstream response handshake.
- ttio_icb_rsp_err, ttio_icb_rsp_rdata  out  1, E203_XLEN  response error and read data.
- lsu_icb_cmd_*  out (ready in)  same fields and widths as ttio_icb_cmd_*  downstream command to LSU-ctrl.
- lsu_icb_rsp_valid/ready, lsu_icb_rsp_err, lsu_icb_rsp_rdata  in/out/in/in  1/1/1/E203_XLEN  downstream response.
- ttio_flush_req  in  1  blocks new command acceptance.
- bridge_busy  out  1  high while any command is queued or outstanding.
- outs_cnt  out  3  current outstanding count.

Function
REQ-005 SHALL accept an upstream command when ttio_icb_cmd_valid & ttio_icb_cmd_ready.
REQ-006 SHALL drive ttio_icb_cmd_ready = ~fifo_full & ~ttio_flush_req.
REQ-007 SHALL store all command fields in an in-order FIFO; an accepted command appears on lsu_icb_cmd_* no earlier than the next cycle (no combinational bypass).
REQ-008 SHALL drive lsu_icb_cmd_valid = ~fifo_empty & (outs_cnt < MAX_OUTS); lsu_icb_cmd_* SHALL present the FIFO head, stable while valid & ~ready.
REQ-009 SHALL pop the FIFO head on lsu_icb_cmd_valid & lsu_icb_cmd_ready.
REQ-010 SHALL allow push and pop in the same cycle when not full; the count is unchanged.
REQ-011 SHALL NOT push when full, even if a pop occurs in the same cycle.
REQ-012 SHALL wrap read and write pointers modulo CMD_DEPTH.
REQ-013 SHALL increment outs_cnt on a downstream command handshake and decrement it on an upstream response handshake; when both occur in one cycle, outs_cnt is unchanged.
REQ-014 SHALL pass responses through combinationally: ttio_icb_rsp_valid/err/rdata = lsu_icb_rsp_*, and lsu_icb_rsp_ready = ttio_icb_rsp_ready (except as in REQ-025).
REQ-015 SHALL leave already-queued commands draining normally while ttio_flush_req is asserted.
REQ-016 SHALL drive bridge_busy = ~fifo_empty | (outs_cnt != 0).
REQ-017 SHALL drive each lsu_icb_cmd_* field only from registered FIFO storage.

Reset
REQ-018 SHALL, on a clk edge with rst_n low, clear the FIFO pointers and count, outs_cnt, timeout counter and orphan counter.
REQ-019 SHALL, during reset, drive ttio_icb_cmd_ready=0, lsu_icb_cmd_valid=0 and bridge_busy=0.
REQ-020 SHALL discard queued and outstanding commands on reset mid-operation, with no response produced for them.
REQ-021 SHALL NOT reset FIFO data storage.

Configuration
REQ-022 SHALL compile the response watchdog only when E203_TTIO_RSP_TIMEOUT_EN is defined.
REQ-023 SHALL, without E203_TTIO_RSP_TIMEOUT_EN, contain no timeout counter or orphan counter, and responses follow REQ-014 only.
REQ-024 SHALL, with the macro defined:
- run a 16-bit counter while outs_cnt != 0 and no downstream response handshake occurs;
- clear the counter on any downstream response handshake or when outs_cnt = 0;
- on reaching RSP_TIMEOUT, present a synthesized response ttio_icb_rsp_valid=1, err=1, rdata=0 until accepted;
- on acceptance of the synthesized response, decrement outs_cnt, increment the orphan counter and clear the timeout counter.
REQ-025 SHALL, while orphan counter > 0, force lsu_icb_rsp_ready=1, suppress ttio_icb_rsp_valid, discard each late LSU response, and decrement the orphan counter per discard.

Structure
REQ-026 SHALL place CMD_DEPTH/MAX_OUTS defaults and the packed command-entry width constant in e203_defines.v.
REQ-027 SHALL implement the FIFO as one sub-module, ttio_icb_cmd_fifo; the outstanding and timeout logic stays in the top module.

Verification
REQ-028 SHALL cover: single read, addr=0x8000_0010, lsu ready=1 -> lsu_icb_cmd_valid one cycle after accept, outs_cnt 0->1->0 after rsp rdata=0xA5A5_5A5A reaches ttio.
REQ-029 SHALL cover: lsu_icb_cmd_ready=0, three back-to-back commands with CMD_DEPTH=2 -> third stalls (ready=0); release -> order addr A,B,C preserved.
REQ-030 SHALL cover: MAX_OUTS=2, no responses -> third lsu_icb_cmd_valid held low until one response is accepted.
REQ-031 SHALL cover: ttio_flush_req=1 with one queued entry -> no new accept; queued entry still issues.
REQ-032 SHALL cover: macro defined, RSP_TIMEOUT=8, no LSU rsp -> err=1 rsp after 8 cycles; later LSU rsp swallowed, ttio rsp_valid stays 0.
REQ-033 SHALL cover: rst_n low with 2 queued and 1 outstanding -> next cycle bridge_busy=0, outs_cnt=0.

Source files
------------

// File: rtl/ttio_icb_bridge_pkg.sv
// ttio_icb_bridge_pkg: shared widths, bridge defaults and the packed command entry
package ttio_icb_bridge_pkg;
  localparam int E203_ADDR_SIZE = 32;
  localparam int E203_XLEN = 32;
  localparam int E203_ITAG_WIDTH = 2;
  localparam int DEF_CMD_DEPTH = 2;
  localparam int DEF_MAX_OUTS = 2;
  typedef struct packed {
    logic [E203_ADDR_SIZE-1:0] addr;
    logic [E203_XLEN-1:0] wdata;
    logic read;
    logic usign;
    logic [E203_XLEN/8-1:0] wmask;
    logic [1:0] size;
    logic [E203_ITAG_WIDTH-1:0] itag;
  } cmd_t;
  localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/ttio_icb_bridge_if.sv
// ttio_icb_bridge_if: ICB command/response bundle; master drives cmd and rsp_ready, slave drives cmd_ready and rsp
interface ttio_icb_bridge_if;
  import ttio_icb_bridge_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [E203_ADDR_SIZE-1:0] cmd_addr;
  logic [E203_XLEN-1:0] cmd_wdata;
  logic cmd_read;
  logic cmd_usign;
  logic [E203_XLEN/8-1:0] cmd_wmask;
  logic [1:0] cmd_size;
  logic [E203_ITAG_WIDTH-1:0] cmd_itag;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_err;
  logic [E203_XLEN-1:0] rsp_rdata;
  modport master (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_read, cmd_usign, cmd_wmask, cmd_size, cmd_itag, rsp_ready,
    input cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport slave (
    input cmd_valid, cmd_addr, cmd_wdata, cmd_read, cmd_usign, cmd_wmask, cmd_size, cmd_itag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/ttio_icb_cmd_fifo.sv
// ttio_icb_cmd_fifo: in-order command FIFO; push_i/din_i write, pop_i/dout_o read head, full_o/empty_o status
module ttio_icb_cmd_fifo
  import ttio_icb_bridge_pkg::*;
#(
  parameter int DEPTH = DEF_CMD_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  cmd_t din_i,
  input  logic pop_i,
  output cmd_t dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic push, pop;
  assign full_o = cnt_q == 3'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign push = push_i & ~full_o;
  assign pop = pop_i & ~empty_o;
  assign dout_o = cmd_t'(mem_q[rp_q]);
  always_comb begin
    wp_d = push ? (wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d = pop ? (rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = cnt_q + 3'(push) - 3'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/ttio_icb_bridge.sv
// ttio_icb_bridge: queues TTIO ICB commands toward LSU-ctrl, limits outstanding ones and returns responses
// ports: clk, rst_n (sync, active-low); ttio (slave bundle from TTIO); lsu (master bundle to LSU-ctrl);
//        ttio_flush_req blocks new accepts; bridge_busy / outs_cnt report queued and outstanding work.
// E203_TTIO_RSP_TIMEOUT_EN adds a response watchdog that answers stuck commands with err=1.
module ttio_icb_bridge
  import ttio_icb_bridge_pkg::*;
#(
  parameter int CMD_DEPTH = DEF_CMD_DEPTH,
  parameter int MAX_OUTS = DEF_MAX_OUTS,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  ttio_icb_bridge_if.slave ttio,
  ttio_icb_bridge_if.master lsu,
  input  logic ttio_flush_req,
  output logic bridge_busy,
  output logic [2:0] outs_cnt
);
  if (CMD_DEPTH < 1 || CMD_DEPTH > 4) begin : g_bad_depth
    $error("CMD_DEPTH out of range");
  end
  if (MAX_OUTS < 1 || MAX_OUTS > 7) begin : g_bad_outs
    $error("MAX_OUTS out of range");
  end
  if (RSP_TIMEOUT < 1 || RSP_TIMEOUT > 65535) begin : g_bad_timeout
    $error("RSP_TIMEOUT out of range");
  end
  cmd_t head, din;
  logic full, empty, cmd_hs, rsp_hs;
  logic [2:0] outs_q, outs_d;
  assign din = {ttio.cmd_addr, ttio.cmd_wdata, ttio.cmd_read, ttio.cmd_usign, ttio.cmd_wmask, ttio.cmd_size, ttio.cmd_itag};
  // rst_n gating keeps handshakes quiet while the synchronous reset is pending
  assign ttio.cmd_ready = rst_n & ~full & ~ttio_flush_req;
  assign lsu.cmd_valid = rst_n & ~empty & (outs_q < 3'(MAX_OUTS));
  assign {lsu.cmd_addr, lsu.cmd_wdata, lsu.cmd_read, lsu.cmd_usign, lsu.cmd_wmask, lsu.cmd_size, lsu.cmd_itag} = head;
  assign cmd_hs = lsu.cmd_valid & lsu.cmd_ready;
  assign rsp_hs = ttio.rsp_valid & ttio.rsp_ready;
  assign outs_d = outs_q + 3'(cmd_hs) - 3'(rsp_hs);
  assign outs_cnt = outs_q;
  assign bridge_busy = rst_n & (~empty | (outs_q != '0));
  ttio_icb_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(ttio.cmd_valid & ttio.cmd_ready),
    .din_i(din),
    .pop_i(cmd_hs),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  always_ff @(posedge clk) outs_q <= !rst_n ? '0 : outs_d;
`ifdef E203_TTIO_RSP_TIMEOUT_EN
  logic [15:0] to_q, to_d;
  logic [2:0] orph_q, orph_d;
  logic to_hit, orph, lsu_hs, syn_acc;
  assign to_hit = to_q == 16'(RSP_TIMEOUT);
  assign orph = orph_q != '0;
  // orphans are late answers to commands already closed by a synthesized error
  assign ttio.rsp_valid = to_hit | (~orph & lsu.rsp_valid);
  assign ttio.rsp_err = to_hit | lsu.rsp_err;
  assign ttio.rsp_rdata = to_hit ? '0 : lsu.rsp_rdata;
  assign lsu.rsp_ready = orph | (~to_hit & ttio.rsp_ready);
  assign lsu_hs = lsu.rsp_valid & lsu.rsp_ready;
  assign syn_acc = to_hit & ttio.rsp_ready;
  always_comb begin
    to_d = (outs_q == '0 | lsu_hs | syn_acc) ? '0 : to_q + 16'(!to_hit);
    orph_d = orph_q + 3'(syn_acc) - 3'(orph & lsu.rsp_valid);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_q <= '0;
      orph_q <= '0;
    end else begin
      to_q <= to_d;
      orph_q <= orph_d;
    end
  end
`else
  assign ttio.rsp_valid = lsu.rsp_valid;
  assign ttio.rsp_err = lsu.rsp_err;
  assign ttio.rsp_rdata = lsu.rsp_rdata;
  assign lsu.rsp_ready = ttio.rsp_ready;
`endif
endmodule
